// File: rtl/chunked_adder_pkg.sv
// chunked_adder_pkg: shared types and helpers for the chunked_adder slice.
//   state_e   - controller state (StIdle, StRun, StDone)
//   idx_width - width of the chunk index counter ($clog2 of chunk count, at least 1)
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// chunked_adder_if: operand and result handshakes of chunked_adder.
//   in_valid/in_ready   - operand handshake carrying a, b, cin, sub
//   out_valid/out_ready - result handshake carrying sum, cout, ovf
//   master modport: producer of operands / consumer of results
//   slave modport:  the adder itself
interface chunked_adder_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/chunk_adder.sv
// chunk_adder: purely combinational CHUNK-bit ripple of full adders.
//   a, b  - CHUNK-bit operand slices
//   ci    - carry into bit 0
//   s     - CHUNK-bit sum slice
//   co    - carry out of the top bit
//   c_msb - carry into the top bit (used for signed overflow)
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle ripple-carry adder, CHUNK bits per clock, carry registered
// between chunks. Latency is WIDTH/CHUNK cycles from accept to out_valid.
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - chunked_adder_if.slave: operand handshake (in_valid/in_ready, a, b, cin, sub)
//           and result handshake (out_valid/out_ready, sum, cout, ovf)
// Build option: define ADDSUB_EN to honour the sub port (a - b via ~b and carry-in 1);
// otherwise the block is add-only and sub is ignored.
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic            clk,
  input logic            rst_n,
  chunked_adder_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IdxW   = idx_width(NCHUNK);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_slice, b_slice, s_slice;
  logic             co, c_msb;

  logic [WIDTH-1:0] b_cap;
  logic             cin_cap;

  // Operand conditioning at capture time.
`ifdef ADDSUB_EN
  always_comb begin
    b_cap   = bus.sub ? ~bus.b : bus.b;
    cin_cap = bus.sub ? 1'b1 : bus.cin;
  end
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  always_comb begin
    b_cap   = bus.b;
    cin_cap = bus.cin;
  end
`endif

  // Select the operand slice for the current chunk.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_slice = a_q[i*CHUNK +: CHUNK];
        b_slice = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk_adder (
    .a    (a_slice),
    .b    (b_slice),
    .ci   (carry_q),
    .s    (s_slice),
    .co   (co),
    .c_msb(c_msb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = b_cap;
          carry_d = cin_cap;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < NCHUNK; i++) begin
          if (idx_q == IdxW'(i)) begin
            sum_d[i*CHUNK +: CHUNK] = s_slice;
          end
        end
        carry_d = co;
        if (idx_q == IdxW'(NCHUNK - 1)) begin
          cout_d  = co;
          // Signed overflow: carry into MSB differs from carry out of MSB.
          ovf_d   = co ^ c_msb;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: scoreboard bench for chunked_adder (WIDTH=16, CHUNK=4) plus a
// CHUNK=WIDTH instance for the single-chunk case.
module tb_chunked_adder;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  chunked_adder_if #(.WIDTH(WIDTH)) bus ();
  chunked_adder_if #(.WIDTH(WIDTH)) bus16 ();

  chunked_adder #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  chunked_adder #(
    .WIDTH(WIDTH),
    .CHUNK(WIDTH)
  ) dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus16)
  );

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic res_t mk(input logic [WIDTH-1:0] s, input logic c, input logic o);
    res_t r;
    r.sum  = s;
    r.cout = c;
    r.ovf  = o;
    return r;
  endfunction

  // Reference: whole-word arithmetic; subtraction as a + ~b + 1 when enabled.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bb;
    logic             c0;
    res_t             r;
    bb = b;
    c0 = cin;
`ifdef ADDSUB_EN
    if (sub) begin
      bb = ~b;
      c0 = 1'b1;
    end
`endif
    full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c0};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  // Monitor: every completed result handshake is checked against the scoreboard.
  always @(negedge clk) begin : monitor
    res_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sum", {16'd0, bus.sum}, {16'd0, e.sum});
        chk("cout", {31'd0, bus.cout}, {31'd0, e.cout});
        chk("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                       input logic sub, input bit push, input res_t e);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_before_issue", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    if (push) exp_q.push_back(e);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input logic sub, input res_t e);
    int lat;
    issue(a, b, cin, sub, 1'b1, e);
    wait_valid(lat);
    chk("latency", lat, NCHUNK);
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    int cnt;
    logic [WIDTH-1:0] ra, rb;
    logic rc, rs;

    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.cin        = 1'b0;
    bus.sub        = 1'b0;
    bus.out_ready  = 1'b1;
    bus16.in_valid = 1'b0;
    bus16.a        = '0;
    bus16.b        = '0;
    bus16.cin      = 1'b0;
    bus16.sub      = 1'b0;
    bus16.out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state.
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_sum", {16'd0, bus.sum}, 32'd0);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);

    // Directed carry/overflow cases.
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b0));
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, mk(16'hFFFF, 1'b1, 1'b0));
`ifdef ADDSUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
`else
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'h000C, 1'b0, 1'b0));
`endif

    // Back-pressure with in_valid pulsed during RUN and DONE.
    bus.out_ready = 1'b0;
    issue(16'h1111, 16'h2222, 1'b1, 1'b0, 1'b1, mk(16'h3334, 1'b0, 1'b0));
    bus.in_valid = 1'b1;
    bus.a        = 16'hFFFF;
    bus.b        = 16'hFFFF;
    chk("bp_run_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_latency", lat, NCHUNK - 1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 2);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_sum", {16'd0, bus.sum}, 32'h3334);
      chk("bp_cout", {31'd0, bus.cout}, 32'd0);
      chk("bp_ovf", {31'd0, bus.ovf}, 32'd0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, model(16'h0F0F, 16'h00F1, 1'b0, 1'b0));

    // Reset during the second RUN cycle discards the operation.
    issue(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0, mk('0, 1'b0, 1'b0));
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_sum", {16'd0, bus.sum}, 32'd0);
    chk("mid_rst_cout", {31'd0, bus.cout}, 32'd0);
    chk("mid_rst_ovf", {31'd0, bus.ovf}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) cnt++;
      tick();
    end
    chk("mid_rst_no_output", cnt, 0);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0));

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    // Single-chunk instance: latency 1.
    chk("c16_in_ready", {31'd0, bus16.in_ready}, 32'd1);
    bus16.in_valid = 1'b1;
    bus16.a        = 16'hABCD;
    bus16.b        = 16'h1111;
    tick();
    bus16.in_valid = 1'b0;
    lat = 0;
    while (!bus16.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("c16_latency", lat, 1);
    chk("c16_sum", {16'd0, bus16.sum}, 32'hBCDE);
    chk("c16_cout", {31'd0, bus16.cout}, 32'd0);
    chk("c16_ovf", {31'd0, bus16.ovf}, 32'd0);
    tick();
    chk("c16_consumed", {31'd0, bus16.out_valid}, 32'd0);

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Multi-cycle, parametrised ripple-carry adder that sums two WIDTH-bit operands CHUNK bits per clock, built from a chain of full adders with a registered inter-chunk carry. It is the sequential successor to the single-cycle half/full adder cells. It serves datapaths where a full-width combinational carry chain would break timing. Operands enter through a valid/ready handshake, and the result leaves through a second valid/ready handshake.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK
- CHUNK, 4, bits added per cycle; NCHUNK = WIDTH/CHUNK, and NCHUNK ≥ 1
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
- in_valid  in  1  operands a, b, cin, sub are valid
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in for add
- sub  in  1  1 = compute a − b; ignored unless ADDSUB_EN is defined
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, registered
- cout  out  1  carry out of MSB; for subtract, 1 means no borrow
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture a and b, plus carry-in (cin, or 1 when subtracting).
  - If subtracting, capture ~b instead of b.
  - chunk index ← 0, then go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, add chunk[idx] of a/b with the carry register.
  - Write the CHUNK-bit result into sum[idx*CHUNK +: CHUNK] and update the carry register.
  - On the last chunk, also record the MSB carry-in (for ovf) and go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf held stable.
  - On out_ready, go to IDLE.
  - A new operation is not accepted in the same cycle.
- in_valid in RUN/DONE is ignored (in_ready=0); the upstream source must hold its operands.
- out_ready outside DONE has no effect.
- Arithmetic is unsigned modulo 2^WIDTH. cout and ovf are both always produced; the consumer picks the one it needs.
- Reset (rst_n=0 at an edge), in any state:
  - State returns to IDLE.
  - sum=0, cout=0, ovf=0, out_valid=0, carry/index cleared.
  - Any in-flight operation is discarded with no output.
- Reset values: in_ready=1 (IDLE), out_valid=0, sum=0, cout=0, ovf=0.

## Timing
- Accept at edge T, i.e. in_valid && in_ready sampled high.
- RUN occupies edges T+1 … T+NCHUNK.
- out_valid is high from after edge T+NCHUNK.
- Latency is NCHUNK cycles from the accept edge to out_valid.
- Minimum issue interval is NCHUNK+2 cycles: accept, NCHUNK RUN cycles, one DONE cycle with out_ready=1, then IDLE.
- NCHUNK=1 (CHUNK=WIDTH) is legal: a single RUN cycle, latency 1.
- The critical path is the CHUNK-bit ripple plus carry-register setup; it is independent of WIDTH.
- in_ready and out_valid are decoded from registered state only, with no combinational input-to-output paths.

## Configuration
- ADDSUB_EN defined:
  - The sub port is honoured.
  - With sub=1, b is inverted on capture and carry-in is forced to 1; cin is ignored.
  - cout=1 means a ≥ b (unsigned).
- ADDSUB_EN undefined:
  - The sub port remains but is ignored; the block is add-only (a+b+cin).
  - No inverter logic is synthesised.

## Structure
- Package chunked_adder_pkg holds the state enum (IDLE, RUN, DONE).
- Sub-module chunk_adder: purely combinational CHUNK-bit ripple of full adders.
  - Inputs: a, b, ci. Outputs: s, co, plus the carry into its MSB (needed for ovf).
  - Instantiated once; chunked_adder muxes the operand slice by index.
- The index counter is $clog2(NCHUNK) bits, minimum 1.

## Test plan
All with WIDTH=16, CHUNK=4 unless stated.
- 0x00FF + 0x0001, cin=0 → sum=0x0100, cout=0, ovf=0; out_valid rises exactly 4 cycles after the accept edge.
- 0xFFFF + 0x0001 → sum=0x0000, cout=1, ovf=0.
- 0x7FFF + 0x0001 → sum=0x8000, cout=0, ovf=1.
- Back-pressure:
  - Stimulus: out_ready held low 5 cycles in DONE, with in_valid pulsed during RUN and DONE.
  - Response: sum/cout/ovf stable, in_ready=0, the pulsed operation is not taken.
  - After out_ready=1, IDLE follows and the next operation is correct.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one edge during the 2nd RUN cycle.
  - Response: next cycle is IDLE, outputs zero, out_valid never asserts for that operation.
  - A subsequent 0x1234 + 0x4321 → 0x5555.
- ADDSUB_EN defined: sub=1, 0x0005 − 0x0007 → sum=0xFFFE, cout=0.
- ADDSUB_EN undefined: same stimulus → sum=0x000C.
- CHUNK=16: 0xABCD + 0x1111 → 0xBCDE, out_valid 1 cycle after accept.
